ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Parametrised instruction prefetch queue between instruction memory and the fetch stage of the pipelined Y86-64 core. Issues aligned multi-byte reads ahead of the PC, buffers bytes in a ring, and presents a sliding window of up to 10 bytes, the longest Y86 instruction, starting at the current fetch PC. The fetch stage consumes a variable number of bytes per cycle. A redirect from branch misprediction or `ret` flushes the queue and restarts fetching from a new PC.

## Interface
- `ADDR_W`, 64: address width.
- `FETCH_BYTES`, 8: bytes per memory read; power of two, ≥ 2.
- `DEPTH`, 32: ring capacity in bytes; power of two, ≥ 2·`FETCH_BYTES`, ≥ 16.
- `RESET_PC`, 0: first fetch PC after reset.

Ports:
- `clk`  in  1  clock; single clock domain, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `redirect`  in  1  flush and restart at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  new fetch PC.
- `mem_req`  out  1  read request (registered).
- `mem_addr`  out  ADDR_W  request address, `FETCH_BYTES`-aligned (registered).
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  8·FETCH_BYTES  read data; byte k at `mem_addr`+k.
- `mem_rerr`  in  1  read fault, qualified by `mem_rvalid`.
- `win_bytes`  out  80  window; byte 0 in bits [7:0] is at `win_pc`.
- `win_cnt`  out  4  valid window bytes, `min(count,10)`.
- `win_pc`  out  ADDR_W  PC of window byte 0.
- `win_err`  out  1  fault pending immediately after the last valid byte.
- `consume`  in  1  fetch stage takes `consume_len` bytes.
- `consume_len`  in  4  1..10.
- `proto_err`  out  1  sticky; illegal consume seen.

## Operation
- State:
  - ring `head`/`tail` pointers and `count` (0..DEPTH)
  - `fetch_addr`, the next aligned read address
  - `outstanding` (0/1); at most one read in flight
  - `drop` flag
  - `err_pend` flag
- Request issue: `mem_req` asserts when `outstanding`=0, `err_pend`=0, and `DEPTH − count ≥ FETCH_BYTES`.
  - `mem_req` and `mem_addr` hold stable until `mem_gnt`.
  - On grant: `outstanding`←1 and `fetch_addr` += `FETCH_BYTES`.
- Response (`mem_rvalid`):
  - Clears `outstanding`.
  - If `drop`=1, the data is discarded and `drop`←0.
  - If `mem_rerr`: no bytes written; `err_pend`←1; requests stop until redirect.
  - Otherwise, bytes are written at `tail`. For the first response after a redirect, bytes below `redirect_pc[log2 FETCH_BYTES−1:0]` are skipped.
- Consume: legal iff `consume_len` ∈ 1..`win_cnt`.
  - A legal consume advances `head`, adds `consume_len` to `win_pc`, and subtracts it from `count`.
  - An illegal consume is ignored and sets `proto_err`.
- Fill and consume in the same cycle: `count` ← `count` + written − consumed.
- Redirect has the highest priority. It overrides consume and response in the same cycle:
  - `count`←0, head=tail, `win_pc`←`redirect_pc`
  - `fetch_addr`←aligned(`redirect_pc`), `err_pend`←0
  - `drop`←`outstanding` (also set if a grant occurs that cycle)
  - An ungranted `mem_req` is withdrawn.
- `win_err` = `err_pend` & (`count` < 10).
- `proto_err` clears only on reset.
- Arithmetic: PC and address adds wrap modulo 2^ADDR_W. Ring pointers wrap modulo DEPTH.
- Reset values:
  - `count` 0, `outstanding` 0, `drop` 0, `err_pend` 0, `proto_err` 0
  - `win_pc`=`RESET_PC`, `fetch_addr`=aligned(`RESET_PC`)
  - `mem_req` 0, `mem_addr` 0
- Reset mid-transaction: any later `mem_rvalid` is not masked, so the memory model must also be reset.

## Timing
- Redirect or reset release at edge N:
  - `mem_req`=1 in cycle N+1.
  - With 1-cycle memory, `mem_rvalid` arrives in N+2.
  - Bytes are visible in the window in N+3.
- Written bytes appear on `win_*` the cycle after `mem_rvalid`; window outputs are combinational from ring state.
- Consume takes effect at the edge. The window reflects the new head the next cycle.
- Back-to-back requests: the next `mem_req` can assert the cycle after `mem_rvalid`, giving sustained 1 read per 2 cycles with 1-cycle memory.

## Structure
- Shared package `y86_pkg` holds:
  - `MAX_INSN_BYTES`=10
  - stat encodings (AOK/HLT/ADR/INS)
  - `ADDR_W` default
- Sub-module `ifq_ring`: byte ring with multi-byte write (`FETCH_BYTES` wide, with start offset) and a 10-byte rotated read port.
- Top-level `ifetch_queue` holds request control, drop/error flags, and PC tracking.

## Test plan
- Reset, `RESET_PC`=0, 1-cycle memory returning bytes 00..1F → `mem_addr` 0 then 8, 16, …; `win_cnt` reaches 10; `win_bytes[7:0]`=00.
- Consume 10 then 2 then 9 (`irmovq`, `addq`, `call`) → `win_pc` 10, 12, 21; window bytes match memory; `count` never exceeds 32; requests stall when full.
- Redirect to 0x103 with a read in flight → stale response dropped; next `mem_addr`=0x100; `win_pc`=0x103; `win_bytes[7:0]`=byte 0x103.
- Redirect, consume and `mem_rvalid` in the same cycle → only the redirect takes effect; `count`=0.
- `mem_rerr` on read at 0x40 with `win_pc`=0x3C → `win_cnt`=4 and `win_err`=1; no further `mem_req` until redirect.
- Consume 7 with `win_cnt`=5 → ignored; `proto_err`=1 and stays 1 until `rst`.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the pipelined Y86-64 core: instruction-length
// limits, status encodings and the default address width.
package y86_pkg;

    localparam int ADDR_W_DEF     = 64;
    localparam int MAX_INSN_BYTES = 10;  // longest Y86 instruction (irmovq/rmmovq/mrmovq)
    localparam int INSN_CNT_W     = 4;   // enough to count 0..MAX_INSN_BYTES

    // Architectural status codes as they appear in the Stat register.
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    // Number of bytes the fetch window can show for a given buffer fill.
    function automatic logic [INSN_CNT_W-1:0] clip_win_cnt(input int unsigned cnt);
        return (cnt >= MAX_INSN_BYTES) ? INSN_CNT_W'(MAX_INSN_BYTES) : INSN_CNT_W'(cnt);
    endfunction

endpackage

// File: rtl/ifq_ring.sv
// Byte ring for the instruction prefetch queue. Accepts one memory line per
// write (optionally skipping its leading bytes) and exposes the
// MAX_INSN_BYTES bytes starting at the read pointer.
module ifq_ring
    import y86_pkg::*;
#(
    parameter int FETCH_BYTES = 8,
    parameter int DEPTH       = 32,
    localparam int OFF_W      = $clog2(FETCH_BYTES),
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [PTR_W-1:0]              wr_ptr,
    input  logic [OFF_W-1:0]              wr_skip,
    input  logic [8*FETCH_BYTES-1:0]      wr_data,
    input  logic [PTR_W-1:0]              rd_ptr,
    output logic [8*MAX_INSN_BYTES-1:0]   rd_bytes
);

    logic [7:0] mem [DEPTH];

    // Line write: byte k of the line lands at wr_ptr + (k - wr_skip) for k >= wr_skip.
    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers in the parent, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                if (OFF_W'(k) >= wr_skip) begin
                    mem[wr_ptr + PTR_W'(k) - PTR_W'(wr_skip)] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // Rotated read port: window byte j comes from ring slot rd_ptr + j.
    always_comb begin
        for (int j = 0; j < MAX_INSN_BYTES; j++) begin
            rd_bytes[8*j +: 8] = mem[rd_ptr + PTR_W'(j)];
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues aligned line reads ahead of the fetch
// PC, buffers the returned bytes in a ring and presents a 10-byte window at
// the current fetch PC. Redirects flush the queue and restart fetching.
module ifetch_queue
    import y86_pkg::*;
#(
    parameter int                  ADDR_W      = ADDR_W_DEF,
    parameter int                  FETCH_BYTES = 8,
    parameter int                  DEPTH       = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    input  logic [8*FETCH_BYTES-1:0]      mem_rdata,
    input  logic                          mem_rerr,
    output logic [8*MAX_INSN_BYTES-1:0]   win_bytes,
    output logic [INSN_CNT_W-1:0]         win_cnt,
    output logic [ADDR_W-1:0]             win_pc,
    output logic                          win_err,
    input  logic                          consume,
    input  logic [INSN_CNT_W-1:0]         consume_len,
    output logic                          proto_err
);

    localparam int OFF_W = $clog2(FETCH_BYTES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] FETCH_STEP  = ADDR_W'(FETCH_BYTES);
    localparam logic [ADDR_W-1:0] RESET_FETCH = {RESET_PC[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Registered state
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_addr;
    logic              outstanding;
    logic              drop;
    logic              err_pend;
    logic              first_resp;   // next kept response is the first after a restart
    logic [OFF_W-1:0]  skip_off;     // leading bytes of that response to discard

    // Next-state values
    logic [PTR_W-1:0]  head_d, tail_d;
    logic [CNT_W-1:0]  count_d;
    logic [ADDR_W-1:0] fetch_d, win_pc_d;
    logic              outstanding_d, drop_d, err_pend_d, first_d, proto_d, mem_req_d;
    logic [OFF_W-1:0]  skip_d;

    // Per-cycle events
    logic              grant;
    logic              resp_live;
    logic              resp_write;
    logic              consume_ok;
    logic [OFF_W-1:0]  skip_now;
    logic [CNT_W-1:0]  wr_n;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  cons_cnt;

    // Decode this cycle's handshake, response and consume events.
    always_comb begin
        grant      = mem_req & mem_gnt;
        resp_live  = mem_rvalid & ~drop;
        resp_write = resp_live & ~mem_rerr;
        skip_now   = first_resp ? skip_off : '0;
        wr_n       = CNT_W'(FETCH_BYTES) - CNT_W'(skip_now);
        wr_cnt     = resp_write ? wr_n : '0;
        consume_ok = consume && (consume_len != '0) && (consume_len <= win_cnt);
        cons_cnt   = consume_ok ? CNT_W'(consume_len) : '0;
    end

    // Next-state computation; a redirect overrides response and consume effects.
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        outstanding_d = outstanding;
        drop_d        = drop;
        err_pend_d    = err_pend;
        first_d       = first_resp;
        skip_d        = skip_off;
        fetch_d       = fetch_addr;
        proto_d       = proto_err;

        if (mem_rvalid) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end
        if (grant) begin
            outstanding_d = 1'b1;
            fetch_d       = fetch_addr + FETCH_STEP;
        end
        if (resp_live) begin
            first_d = 1'b0;
            if (mem_rerr) begin
                err_pend_d = 1'b1;
            end
        end
        if (consume && !consume_ok) begin
            proto_d = 1'b1;
        end

        tail_d   = resp_write ? tail + PTR_W'(wr_n) : tail;
        head_d   = head + PTR_W'(cons_cnt);
        count_d  = count + wr_cnt - cons_cnt;
        win_pc_d = win_pc + ADDR_W'(cons_cnt);

        if (redirect) begin
            head_d     = tail;
            tail_d     = tail;
            count_d    = '0;
            win_pc_d   = redirect_pc;
            fetch_d    = {redirect_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            err_pend_d = 1'b0;
            first_d    = 1'b1;
            skip_d     = redirect_pc[OFF_W-1:0];
            proto_d    = proto_err;
            // Only a read still in flight after this edge needs discarding:
            // one completing this cycle is already ignored, one granted now is not.
            drop_d     = outstanding_d;
        end

        mem_req_d = !outstanding_d && !err_pend_d &&
                    ((CNT_W'(DEPTH) - count_d) >= CNT_W'(FETCH_BYTES));
    end

    // State registers and registered memory-request outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_addr  <= RESET_FETCH;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            err_pend    <= 1'b0;
            first_resp  <= 1'b1;
            skip_off    <= RESET_PC[OFF_W-1:0];
            win_pc      <= RESET_PC;
            proto_err   <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            head        <= head_d;
            tail        <= tail_d;
            count       <= count_d;
            fetch_addr  <= fetch_d;
            outstanding <= outstanding_d;
            drop        <= drop_d;
            err_pend    <= err_pend_d;
            first_resp  <= first_d;
            skip_off    <= skip_d;
            win_pc      <= win_pc_d;
            proto_err   <= proto_d;
            mem_req     <= mem_req_d;
            mem_addr    <= fetch_d;
        end
    end

    // Window status derived directly from ring occupancy.
    always_comb begin
        win_cnt = clip_win_cnt(32'(count));
        win_err = err_pend && (count < CNT_W'(MAX_INSN_BYTES));
    end

    ifq_ring #(
        .FETCH_BYTES (FETCH_BYTES),
        .DEPTH       (DEPTH)
    ) u_ring (
        .clk      (clk),
        .wr_en    (resp_write && !redirect),
        .wr_ptr   (tail),
        .wr_skip  (skip_now),
        .wr_data  (mem_rdata),
        .rd_ptr   (head),
        .rd_bytes (win_bytes)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a small 1..N-cycle instruction memory.
module tb_ifetch_queue;
    import y86_pkg::*;

    localparam int ADDR_W = 64;
    localparam int FB     = 8;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [8*FB-1:0]   mem_rdata;
    logic              mem_rerr;
    logic [79:0]       win_bytes;
    logic [3:0]        win_cnt;
    logic [ADDR_W-1:0] win_pc;
    logic              win_err;
    logic              consume = 1'b0;
    logic [3:0]        consume_len = '0;
    logic              proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory model controls
    logic              gnt_en = 1'b1;
    int                lat = 0;
    logic              err_en = 1'b0;
    logic [ADDR_W-1:0] err_addr = '0;

    // Memory model state
    logic              pend;
    int                wait_cnt;
    logic [ADDR_W-1:0] paddr;
    int                cyc;
    int                n_grants;
    logic [ADDR_W-1:0] grant_addr [64];
    int                grant_cyc  [64];

    ifetch_queue #(
        .ADDR_W(ADDR_W), .FETCH_BYTES(FB), .DEPTH(DEPTH), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
        .win_bytes(win_bytes), .win_cnt(win_cnt), .win_pc(win_pc), .win_err(win_err),
        .consume(consume), .consume_len(consume_len), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    assign mem_gnt = mem_req & gnt_en;

    // Memory contents: identity below 0x100, distinct pattern above.
    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {a[11:8], 4'h0};
    endfunction

    function automatic logic [8*FB-1:0] line_of(input logic [ADDR_W-1:0] a);
        logic [8*FB-1:0] r;
        for (int k = 0; k < FB; k++) r[8*k +: 8] = mem_byte(a + ADDR_W'(k));
        return r;
    endfunction

    function automatic logic [79:0] exp_win(input logic [ADDR_W-1:0] pc, input int n);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = mem_byte(pc + ADDR_W'(k));
        return r;
    endfunction

    function automatic logic [79:0] win_mask(input int n);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    // Memory: grant latches the address; data returns lat cycles after the grant edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= 1'b0;
            wait_cnt   <= 0;
            paddr      <= '0;
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            mem_rerr   <= 1'b0;
            n_grants   <= 0;
            cyc        <= 0;
        end else begin
            cyc        <= cyc + 1;
            mem_rvalid <= 1'b0;
            mem_rerr   <= 1'b0;
            if (mem_req && mem_gnt) begin
                if (n_grants < 64) begin
                    grant_addr[n_grants] <= mem_addr;
                    grant_cyc[n_grants]  <= cyc;
                end
                n_grants <= n_grants + 1;
                if (lat == 0) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= line_of(mem_addr);
                    mem_rerr   <= err_en && (mem_addr == err_addr);
                end else begin
                    pend     <= 1'b1;
                    paddr    <= mem_addr;
                    wait_cnt <= lat - 1;
                end
            end else if (pend) begin
                if (wait_cnt == 0) begin
                    pend       <= 1'b0;
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= line_of(paddr);
                    mem_rerr   <= err_en && (paddr == err_addr);
                end else begin
                    wait_cnt <= wait_cnt - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        bit found = 0;
        for (int i = 0; i < 12; i++) begin
            if (mem_req) begin found = 1; break; end
            tick();
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL %s: mem_req never asserted within 12 cycles", name); end
    endtask

    task automatic wait_win(input string name);
        bit found = 0;
        for (int i = 0; i < 12; i++) begin
            if (win_cnt != 0) begin found = 1; break; end
            tick();
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL %s: window stayed empty for 12 cycles", name); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== '0) begin n_bad++; $display("FAIL reset_req: req=%b addr=%h expected 0/0", mem_req, mem_addr); end
        n_cmp++; if (win_cnt !== 4'd0 || win_pc !== '0) begin n_bad++; $display("FAIL reset_win: cnt=%0d pc=%h expected 0/0", win_cnt, win_pc); end
        n_cmp++; if (proto_err !== 1'b0 || win_err !== 1'b0) begin n_bad++; $display("FAIL reset_flags: proto=%b err=%b expected 0/0", proto_err, win_err); end
        tick();
        tick();
        rst = 1'b0;
        tick();  // edge N
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin n_bad++; $display("FAIL first_req: req=%b addr=%h expected 1/0", mem_req, mem_addr); end
        tick();  // grant taken
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL req_drop_after_gnt: req=%b expected 0", mem_req); end
        tick();  // data written
        n_cmp++; if (win_cnt !== 4'd8 || win_bytes[7:0] !== 8'h00) begin n_bad++; $display("FAIL first_fill: cnt=%0d b0=%h expected 8/00", win_cnt, win_bytes[7:0]); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h8) begin n_bad++; $display("FAIL second_req: req=%b addr=%h expected 1/8", mem_req, mem_addr); end
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < 12; i++) tick();
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL full_stall: req=%b expected 0", mem_req); end
        n_cmp++; if (n_grants !== 4) begin n_bad++; $display("FAIL full_grants: got %0d expected 4", n_grants); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (grant_addr[i] !== ADDR_W'(8*i)) begin n_bad++; $display("FAIL fill_addr%0d: got %h expected %h", i, grant_addr[i], 8*i); end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (grant_cyc[i+1] - grant_cyc[i] !== 2) begin n_bad++; $display("FAIL back_to_back%0d: spacing %0d expected 2", i, grant_cyc[i+1] - grant_cyc[i]); end
        end
        n_cmp++; if (win_cnt !== 4'd10 || win_bytes !== exp_win(64'h0, 10)) begin n_bad++; $display("FAIL full_window: cnt=%0d bytes=%h expected 10/%h", win_cnt, win_bytes, exp_win(64'h0, 10)); end
    endtask

    task automatic test_consume();
        consume = 1'b1; consume_len = 4'd10;  // irmovq
        tick();
        n_cmp++; if (win_pc !== 64'd10 || win_bytes !== exp_win(64'd10, 10)) begin n_bad++; $display("FAIL consume10: pc=%h bytes=%h expected a/%h", win_pc, win_bytes, exp_win(64'd10, 10)); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'd32) begin n_bad++; $display("FAIL refill_req: req=%b addr=%h expected 1/20", mem_req, mem_addr); end
        consume_len = 4'd2;  // addq
        tick();
        n_cmp++; if (win_pc !== 64'd12 || win_bytes !== exp_win(64'd12, 10)) begin n_bad++; $display("FAIL consume2: pc=%h bytes=%h expected c/%h", win_pc, win_bytes, exp_win(64'd12, 10)); end
        consume_len = 4'd9;  // call, same edge as the refill write
        tick();
        consume = 1'b0;
        n_cmp++; if (win_pc !== 64'd21 || win_cnt !== 4'd10 || win_bytes !== exp_win(64'd21, 10)) begin n_bad++; $display("FAIL consume9_fill: pc=%h cnt=%0d bytes=%h expected 15/10/%h", win_pc, win_cnt, win_bytes, exp_win(64'd21, 10)); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'd40) begin n_bad++; $display("FAIL next_req: req=%b addr=%h expected 1/28", mem_req, mem_addr); end
    endtask

    task automatic test_redirect_drop();
        lat = 3;
        tick();  // read at 0x28 granted, stays in flight
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL inflight_req: req=%b expected 0", mem_req); end
        redirect = 1'b1; redirect_pc = 64'h103;
        tick();
        redirect = 1'b0; lat = 0;
        n_cmp++; if (win_pc !== 64'h103 || win_cnt !== 4'd0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL redirect_state: pc=%h cnt=%0d req=%b expected 103/0/0", win_pc, win_cnt, mem_req); end
        wait_req("redirect_req_wait");
        n_cmp++; if (mem_addr !== 64'h100 || win_cnt !== 4'd0) begin n_bad++; $display("FAIL redirect_addr: addr=%h cnt=%0d expected 100/0", mem_addr, win_cnt); end
        wait_win("redirect_fill_wait");
        n_cmp++; if (win_cnt !== 4'd5 || win_pc !== 64'h103) begin n_bad++; $display("FAIL redirect_skip: cnt=%0d pc=%h expected 5/103", win_cnt, win_pc); end
        n_cmp++; if ((win_bytes & win_mask(5)) !== exp_win(64'h103, 5)) begin n_bad++; $display("FAIL redirect_bytes: got %h expected %h", win_bytes & win_mask(5), exp_win(64'h103, 5)); end
    endtask

    task automatic test_redirect_collision();
        wait_req("collide_req_wait");
        tick();  // grant; response returns on the next edge
        n_cmp++; if (mem_rvalid !== 1'b1) begin n_bad++; $display("FAIL collide_setup: rvalid=%b expected 1", mem_rvalid); end
        redirect = 1'b1; redirect_pc = 64'h200;
        consume = 1'b1; consume_len = 4'd2;
        tick();
        redirect = 1'b0; consume = 1'b0;
        n_cmp++; if (win_cnt !== 4'd0 || win_pc !== 64'h200 || proto_err !== 1'b0) begin n_bad++; $display("FAIL collide_state: cnt=%0d pc=%h proto=%b expected 0/200/0", win_cnt, win_pc, proto_err); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h200) begin n_bad++; $display("FAIL collide_req: req=%b addr=%h expected 1/200", mem_req, mem_addr); end
        wait_win("collide_fill_wait");
        n_cmp++; if (win_cnt !== 4'd8 || (win_bytes & win_mask(8)) !== exp_win(64'h200, 8)) begin n_bad++; $display("FAIL collide_fill: cnt=%0d bytes=%h expected 8/%h", win_cnt, win_bytes & win_mask(8), exp_win(64'h200, 8)); end
    endtask

    task automatic test_rerr();
        bit found = 0;
        bit quiet = 1;
        err_en = 1'b1; err_addr = 64'h40;
        redirect = 1'b1; redirect_pc = 64'h38;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (win_cnt == 4'd8) begin found = 1; break; end
            tick();
        end
        n_cmp++; if (!found || win_pc !== 64'h38) begin n_bad++; $display("FAIL rerr_setup: found=%b pc=%h expected 1/38", found, win_pc); end
        consume = 1'b1; consume_len = 4'd4;
        tick();
        consume = 1'b0;
        tick();
        n_cmp++; if (win_cnt !== 4'd4 || win_pc !== 64'h3C || win_err !== 1'b1) begin n_bad++; $display("FAIL rerr_window: cnt=%0d pc=%h err=%b expected 4/3c/1", win_cnt, win_pc, win_err); end
        n_cmp++; if ((win_bytes & win_mask(4)) !== exp_win(64'h3C, 4)) begin n_bad++; $display("FAIL rerr_bytes: got %h expected %h", win_bytes & win_mask(4), exp_win(64'h3C, 4)); end
        for (int i = 0; i < 6; i++) begin
            if (mem_req !== 1'b0) quiet = 0;
            tick();
        end
        n_cmp++; if (!quiet) begin n_bad++; $display("FAIL rerr_no_req: got a mem_req, expected none"); end
        err_en = 1'b0;
    endtask

    task automatic test_gnt_stall();
        bit steady = 1;
        gnt_en = 1'b0;
        redirect = 1'b1; redirect_pc = 64'h300;
        tick();
        redirect = 1'b0;
        n_cmp++; if (win_err !== 1'b0 || mem_req !== 1'b1) begin n_bad++; $display("FAIL err_cleared: err=%b req=%b expected 0/1", win_err, mem_req); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_req !== 1'b1 || mem_addr !== 64'h300) steady = 0;
        end
        n_cmp++; if (!steady) begin n_bad++; $display("FAIL req_hold: req=%b addr=%h expected 1/300 held", mem_req, mem_addr); end
    endtask

    task automatic test_proto();
        gnt_en = 1'b1;  // stalled read at 0x300 granted on the redirect edge
        redirect = 1'b1; redirect_pc = 64'h403;
        tick();
        redirect = 1'b0;
        wait_req("proto_req_wait");
        n_cmp++; if (mem_addr !== 64'h400) begin n_bad++; $display("FAIL proto_req_addr: got %h expected 400", mem_addr); end
        tick();
        gnt_en = 1'b0;
        wait_win("proto_fill_wait");
        n_cmp++; if (win_cnt !== 4'd5 || win_bytes[7:0] !== mem_byte(64'h403)) begin n_bad++; $display("FAIL proto_setup: cnt=%0d b0=%h expected 5/%h", win_cnt, win_bytes[7:0], mem_byte(64'h403)); end
        consume = 1'b1; consume_len = 4'd7;
        tick();
        n_cmp++; if (proto_err !== 1'b1 || win_cnt !== 4'd5 || win_pc !== 64'h403) begin n_bad++; $display("FAIL illegal_consume: proto=%b cnt=%0d pc=%h expected 1/5/403", proto_err, win_cnt, win_pc); end
        consume_len = 4'd5;
        tick();
        consume = 1'b0;
        n_cmp++; if (proto_err !== 1'b1 || win_cnt !== 4'd0 || win_pc !== 64'h408) begin n_bad++; $display("FAIL legal_after: proto=%b cnt=%0d pc=%h expected 1/0/408", proto_err, win_cnt, win_pc); end
        redirect = 1'b1; redirect_pc = 64'h500;
        tick();
        redirect = 1'b0;
        n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
        rst = 1'b1;
        #1;
        n_cmp++; if (proto_err !== 1'b0 || win_pc !== '0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL async_reset: proto=%b pc=%h req=%b expected 0/0/0", proto_err, win_pc, mem_req); end
        tick();
        rst = 1'b0;
        gnt_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_consume();
        test_redirect_drop();
        test_redirect_collision();
        test_rerr();
        test_gnt_stall();
        test_proto();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
